memory_arbiter: RTL
===================

// Module: memory_arbiter
// PURPOSE
//  Two-port round-robin controller that shares the single-port-per-direction `memory` block (sync write,
//  1-cycle registered read) between requesters A (port 0) and B (port 1). Serialises one access per cycle.
//  Optionally sweeps the array to CLEAR_VALUE after reset, then arbitrates.
//  Sits between client logic and `memory`; drives all memory control pins.
// PARAMETERS
//  ADDR_W          4   memory address width (depth = 2**ADDR_W)
//  DATA_W          8   memory data width
//  CLEAR_ON_RESET  1   1: run clear sweep after reset; 0: go straight to RUN
//  CLEAR_VALUE     0   DATA_W-bit word written during sweep
// PORTS
//  clk          in   1       system clock, all logic on rising edge
//  rst_n        in   1       asynchronous active-low reset
//  busy         out  1       high while clear sweep in progress
//  a_req/b_req  in   1       access request; held until grant
//  a_we/b_we    in   1       1 = write, 0 = read (valid with req)
//  a_addr/b_addr in  ADDR_W  access address
//  a_wdata/b_wdata in DATA_W write data
//  a_gnt/b_gnt  out  1       one-cycle pulse: request accepted
//  a_rvalid/b_rvalid out 1   one-cycle pulse: read data on *_rdata
//  a_rdata/b_rdata out DATA_W read data (= mem_r_data, shared)
//  mem_w_en/mem_r_en out 1   to memory w_en / r_en (registered)
//  mem_w_addr/mem_r_addr out ADDR_W  to memory addresses (registered)
//  mem_w_data   out  DATA_W  to memory w_data (registered)
//  mem_r_data   in   DATA_W  from memory r_data
// BEHAVIOUR
//  - Reset: all outputs 0; busy=CLEAR_ON_RESET; state=CLEAR (or RUN); clr_cnt=0; rr_last=B (A wins first tie).
//  - FSM CLEAR: each cycle registers mem_w_en=1, mem_w_addr=clr_cnt, mem_w_data=CLEAR_VALUE; clr_cnt++.
//    After addr 2**ADDR_W-1 issued -> RUN, busy=0 same edge. Requests ignored (no gnt) in CLEAR.
//  - FSM RUN, cycle N: eligible_x = x_req & ~x_gnt (port granted this cycle is masked, preventing double grant).
//    One eligible -> it wins; both -> port != rr_last wins; rr_last <= winner. None -> mem enables 0.
//  - Edge end of N: x_gnt<=1 for winner (visible cycle N+1); mem_w_en/mem_r_en<=we/~we, addr/data registered.
//    Memory executes at edge end of N+1; read data valid cycle N+2: x_rvalid=1 for exactly that cycle.
//  - Requester may change req/addr at edge ending its gnt cycle; per-port max rate 1 per 2 cycles,
//    aggregate 1 per cycle when both ports busy.
//  - Ordering: accesses complete in grant order; write at N then read same addr at N+1 returns new data.
//  - Only one of mem_w_en/mem_r_en high in any cycle; never both.
//  - rvalid pipeline: 2-stage shift of {valid,port}; unaffected by new grants.
//  - Reset mid-operation: in-flight reads dropped (no rvalid), sweep restarts from addr 0 if CLEAR_ON_RESET.
//  - clr_cnt is ADDR_W+1 bits; terminal detect on MSB, no wrap into addr 0 twice.
// STRUCTURE
//  - memory_arbiter_defs.vh: state encodings ST_CLEAR=1'b0, ST_RUN=1'b1; port ids PORT_A=0, PORT_B=1.
//  - One sub-module rr_arb2 (2-way round-robin: req[1:0], last -> gnt_onehot[1:0]) purely combinational;
//    FSM, clear counter, command registers, rvalid pipe in top.
// TESTING (bench instantiates memory_arbiter + memory, ADDR_W=4, DATA_W=8)
//  - Reset release, CLEAR_ON_RESET=1 -> busy high 16 cycles, writes addr 0..15 with 0x00, then all reads return 0x00.
//  - A write addr 0xF data 0xA5, then A read 0xF -> a_gnt each, a_rvalid 2 cycles after read gnt, a_rdata=0xA5.
//  - A and B both read continuously (A addr 3, B addr 7) -> grants alternate A,B,A,B; no port starved; rvalid matches port.
//  - Same-cycle A write 0x5=0x3C and B read 0x5 -> A granted first; B read returns 0x3C.
//  - rst_n pulsed low one cycle after a read gnt -> no rvalid emitted, mem enables 0 during reset, sweep restarts at addr 0.
//  - Requests during busy -> no gnt until RUN; first RUN cycle grants A if both pending.

Source files
------------

// File: rtl/memory_arbiter_pkg.sv
// Shared definitions for the two-port memory arbiter.
//   state_e    : controller states (clear sweep, normal arbitration)
//   PORT_A/B   : requester identifiers, also the encoding of rr_last and the rvalid tag
//   rd_tag_t   : one stage of the read-return pipeline {valid, port}
package memory_arbiter_pkg;

   typedef enum logic [0:0] {
      StClear = 1'b0,
      StRun   = 1'b1
   } state_e;

   localparam logic PORT_A = 1'b0;
   localparam logic PORT_B = 1'b1;

   typedef struct packed {
      logic valid;
      logic port;
   } rd_tag_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter, purely combinational.
//   req        in  2  request vector, bit 0 = port A, bit 1 = port B
//   last       in  1  port that won the previous arbitration
//   gnt_onehot out 2  one-hot winner (all zero when no request)
module rr_arb2
   import memory_arbiter_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last,
   output logic [1:0] gnt_onehot
);

   always_comb begin
      gnt_onehot = 2'b00;
      unique case (req)
         2'b01:   gnt_onehot = 2'b01;
         2'b10:   gnt_onehot = 2'b10;
         // Tie goes to whichever port did not win last time.
         2'b11:   gnt_onehot = (last == PORT_B) ? 2'b01 : 2'b10;
         default: gnt_onehot = 2'b00;
      endcase
   end

endmodule

// File: rtl/memory_arbiter.sv
// Round-robin controller sharing one memory (sync write, 1-cycle registered read) between
// requesters A and B. One access per cycle; optional clear sweep after reset.
//   clk, rst_n                 clock, asynchronous active-low reset
//   busy                       high while the clear sweep runs
//   a_/b_req, _we, _addr, _wdata  request side (req held until gnt)
//   a_/b_gnt                   one-cycle accept pulse
//   a_/b_rvalid, _rdata        one-cycle read-return pulse, data shared from mem_r_data
//   mem_w_en/_addr/_data       registered memory write port
//   mem_r_en/_addr, mem_r_data registered memory read port and returned data
module memory_arbiter
   import memory_arbiter_pkg::*;
#(
   parameter int unsigned       ADDR_W         = 4,
   parameter int unsigned       DATA_W         = 8,
   parameter bit                CLEAR_ON_RESET = 1'b1,
   parameter logic [DATA_W-1:0] CLEAR_VALUE    = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic              busy,
   input  logic              a_req,
   input  logic              a_we,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [DATA_W-1:0] a_wdata,
   output logic              a_gnt,
   output logic              a_rvalid,
   output logic [DATA_W-1:0] a_rdata,
   input  logic              b_req,
   input  logic              b_we,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [DATA_W-1:0] b_wdata,
   output logic              b_gnt,
   output logic              b_rvalid,
   output logic [DATA_W-1:0] b_rdata,
   output logic              mem_w_en,
   output logic [ADDR_W-1:0] mem_w_addr,
   output logic [DATA_W-1:0] mem_w_data,
   output logic              mem_r_en,
   output logic [ADDR_W-1:0] mem_r_addr,
   input  logic [DATA_W-1:0] mem_r_data
);

   localparam state_e StReset = CLEAR_ON_RESET ? StClear : StRun;

   state_e              state_q, state_d;
   logic [ADDR_W:0]     clr_cnt_q, clr_cnt_d, clr_cnt_inc;
   logic                busy_q, busy_d;
   logic                rr_last_q, rr_last_d;
   logic                a_gnt_q, a_gnt_d;
   logic                b_gnt_q, b_gnt_d;
   logic                mem_w_en_q, mem_w_en_d;
   logic                mem_r_en_q, mem_r_en_d;
   logic [ADDR_W-1:0]   mem_w_addr_q, mem_w_addr_d;
   logic [ADDR_W-1:0]   mem_r_addr_q, mem_r_addr_d;
   logic [DATA_W-1:0]   mem_w_data_q, mem_w_data_d;
   rd_tag_t             pipe0_q, pipe0_d;
   rd_tag_t             pipe1_q, pipe1_d;

   logic [1:0]          eligible;
   logic [1:0]          win;
   logic                sel_b;
   logic                sel_we;
   logic [ADDR_W-1:0]   sel_addr;
   logic [DATA_W-1:0]   sel_wdata;

   // A port granted this cycle is masked so a held request is not accepted twice.
   assign eligible = {b_req & ~b_gnt_q, a_req & ~a_gnt_q};

   rr_arb2 u_rr_arb2 (
      .req        (eligible),
      .last       (rr_last_q),
      .gnt_onehot (win)
   );

   assign sel_b       = win[1];
   assign sel_we      = sel_b ? b_we    : a_we;
   assign sel_addr    = sel_b ? b_addr  : a_addr;
   assign sel_wdata   = sel_b ? b_wdata : a_wdata;
   assign clr_cnt_inc = clr_cnt_q + 1'b1;

   always_comb begin
      state_d      = state_q;
      clr_cnt_d    = clr_cnt_q;
      busy_d       = busy_q;
      rr_last_d    = rr_last_q;
      a_gnt_d      = 1'b0;
      b_gnt_d      = 1'b0;
      mem_w_en_d   = 1'b0;
      mem_r_en_d   = 1'b0;
      mem_w_addr_d = mem_w_addr_q;
      mem_r_addr_d = mem_r_addr_q;
      mem_w_data_d = mem_w_data_q;
      pipe0_d      = '0;
      // Second stage always advances; new grants only load the first stage.
      pipe1_d      = pipe0_q;

      unique case (state_q)
         StClear: begin
            mem_w_en_d   = 1'b1;
            mem_w_addr_d = clr_cnt_q[ADDR_W-1:0];
            mem_w_data_d = CLEAR_VALUE;
            clr_cnt_d    = clr_cnt_inc;
            // MSB set means the last address is being issued this cycle.
            if (clr_cnt_inc[ADDR_W]) begin
               state_d = StRun;
               busy_d  = 1'b0;
            end
         end
         StRun: begin
            if (|win) begin
               a_gnt_d   = win[0];
               b_gnt_d   = win[1];
               rr_last_d = sel_b;
               if (sel_we) begin
                  mem_w_en_d   = 1'b1;
                  mem_w_addr_d = sel_addr;
                  mem_w_data_d = sel_wdata;
               end else begin
                  mem_r_en_d   = 1'b1;
                  mem_r_addr_d = sel_addr;
                  pipe0_d      = '{valid: 1'b1, port: sel_b};
               end
            end
         end
         default: state_d = StRun;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StReset;
         clr_cnt_q    <= '0;
         busy_q       <= CLEAR_ON_RESET;
         rr_last_q    <= PORT_B;
         a_gnt_q      <= 1'b0;
         b_gnt_q      <= 1'b0;
         mem_w_en_q   <= 1'b0;
         mem_r_en_q   <= 1'b0;
         mem_w_addr_q <= '0;
         mem_r_addr_q <= '0;
         mem_w_data_q <= '0;
         pipe0_q      <= '0;
         pipe1_q      <= '0;
      end else begin
         state_q      <= state_d;
         clr_cnt_q    <= clr_cnt_d;
         busy_q       <= busy_d;
         rr_last_q    <= rr_last_d;
         a_gnt_q      <= a_gnt_d;
         b_gnt_q      <= b_gnt_d;
         mem_w_en_q   <= mem_w_en_d;
         mem_r_en_q   <= mem_r_en_d;
         mem_w_addr_q <= mem_w_addr_d;
         mem_r_addr_q <= mem_r_addr_d;
         mem_w_data_q <= mem_w_data_d;
         pipe0_q      <= pipe0_d;
         pipe1_q      <= pipe1_d;
      end
   end

   assign busy       = busy_q;
   assign a_gnt      = a_gnt_q;
   assign b_gnt      = b_gnt_q;
   assign mem_w_en   = mem_w_en_q;
   assign mem_r_en   = mem_r_en_q;
   assign mem_w_addr = mem_w_addr_q;
   assign mem_r_addr = mem_r_addr_q;
   assign mem_w_data = mem_w_data_q;
   assign a_rvalid   = pipe1_q.valid & (pipe1_q.port == PORT_A);
   assign b_rvalid   = pipe1_q.valid & (pipe1_q.port == PORT_B);
   assign a_rdata    = mem_r_data;
   assign b_rdata    = mem_r_data;

endmodule
